// File: rtl/k052109_pkg.sv
// Shared types and constants for the k052109 tile fetch slice.
package k052109_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CODE,
    RD_ATTR,
    CAP_ATTR,
    EMIT
  } fetch_state_t;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned ROM_AW  = 16;

  // Attribute byte layout
  localparam int unsigned ATTR_TILE8    = 0;
  localparam int unsigned ATTR_FLIPY    = 1;
  localparam int unsigned ATTR_BANK_LO  = 2;
  localparam int unsigned ATTR_BANK_HI  = 3;
  localparam int unsigned ATTR_COLOR_LO = 4;
  localparam int unsigned ATTR_COLOR_HI = 7;

  function automatic logic [2:0] tile_row(input logic [2:0] row, input logic flip);
    return row ^ {3{flip}};
  endfunction

endpackage

// File: rtl/k052109_tile_fetch_if.sv
// Slot request, bank write, VRAM read and pixel-side output signals of one layer.
interface k052109_tile_fetch_if;
  import k052109_pkg::*;

  logic                start;
  logic [10:0]         map;
  logic [2:0]          row_s;
  logic [2:0]          fine;
  logic                bank_we;
  logic [1:0]          bank_sel;
  logic [3:0]          bank_data;
  logic [VRAM_AW-1:0]  vram_addr;
  logic                vram_rd;
  logic                vram_wait;
  logic [7:0]          vd_in;
  logic [ROM_AW-1:0]   rom_addr;
  logic [3:0]          color;
  logic [2:0]          fine_out;
  logic                tile_valid;
  logic                overrun;

  modport master (
    output start, map, row_s, fine, bank_we, bank_sel, bank_data, vram_wait, vd_in,
    input  vram_addr, vram_rd, rom_addr, color, fine_out, tile_valid, overrun
  );

  modport slave (
    input  start, map, row_s, fine, bank_we, bank_sel, bank_data, vram_wait, vd_in,
    output vram_addr, vram_rd, rom_addr, color, fine_out, tile_valid, overrun
  );

endinterface

// File: rtl/k052109_bank_regs.sv
// Four 4-bit tile bank registers: one CPU write port, one combinational read port.
module k052109_bank_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] sel,
  input  logic [3:0] data,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_data
);

  logic [3:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[sel] <= data;
    end
  end

  assign rd_data = regs[rd_sel];

endmodule

// File: rtl/k052109_tile_fetch.sv
// Per-layer tile fetch: reads code and attribute bytes from VRAM and emits a tile ROM row address.
module k052109_tile_fetch
  import k052109_pkg::*;
#(
  parameter logic [VRAM_AW-1:0] CODE_BASE = 13'h0000,
  parameter logic [VRAM_AW-1:0] ATTR_BASE = 13'h0800,
  parameter bit                 FLIPY_EN  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  k052109_tile_fetch_if.slave  bus
);

  fetch_state_t       state, state_n;
  logic [10:0]        map_q;
  logic [2:0]         row_q, fine_q;
  logic [7:0]         code_q;
  logic               code_pend;
  logic [VRAM_AW-1:0] code_addr, attr_addr, vram_addr;
  logic               vram_rd;
  logic               busy;
  logic [3:0]         bank_val;
  logic [ROM_AW-1:0]  rom_addr;
  logic [3:0]         color;
  logic [2:0]         fine_out;
  logic               overrun;

  assign code_addr = CODE_BASE + {2'b00, map_q};
  assign attr_addr = ATTR_BASE + {2'b00, map_q};
  assign busy      = (state == RD_CODE) || (state == RD_ATTR) || (state == CAP_ATTR);

  k052109_bank_regs u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.bank_we),
    .sel     (bus.bank_sel),
    .data    (bus.bank_data),
    .rd_sel  (bus.vd_in[ATTR_BANK_HI:ATTR_BANK_LO]),
    .rd_data (bank_val)
  );

  always_comb begin
    state_n   = state;
    vram_rd   = 1'b0;
    vram_addr = '0;
    unique case (state)
      IDLE: ;
      RD_CODE: begin
        vram_rd   = 1'b1;
        vram_addr = code_addr;
        if (!bus.vram_wait) state_n = RD_ATTR;
      end
      RD_ATTR: begin
        vram_rd   = 1'b1;
        vram_addr = attr_addr;
        if (!bus.vram_wait) state_n = CAP_ATTR;
      end
      CAP_ATTR: state_n = EMIT;
      EMIT:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (bus.start) state_n = RD_CODE;
  end

  // Outputs load on the CAP_ATTR->EMIT edge straight from the attribute byte on
  // VD_IN, so TILE_VALID (EMIT) lines up with them and an EMIT-cycle bank write is unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      map_q     <= '0;
      row_q     <= '0;
      fine_q    <= '0;
      code_q    <= '0;
      code_pend <= 1'b0;
      rom_addr  <= '0;
      color     <= '0;
      fine_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      code_pend <= (state == RD_CODE) && !bus.vram_wait && !bus.start;
      if (bus.start) begin
        map_q  <= bus.map;
        row_q  <= bus.row_s;
        fine_q <= bus.fine;
        if (busy) overrun <= 1'b1;
      end
      if ((state == RD_ATTR) && code_pend) code_q <= bus.vd_in;
      if ((state == CAP_ATTR) && !bus.start) begin
        rom_addr <= {bank_val, bus.vd_in[ATTR_TILE8], code_q,
                     tile_row(row_q, FLIPY_EN & bus.vd_in[ATTR_FLIPY])};
        color    <= bus.vd_in[ATTR_COLOR_HI:ATTR_COLOR_LO];
        fine_out <= fine_q;
      end
    end
  end

  assign bus.vram_addr  = vram_addr;
  assign bus.vram_rd    = vram_rd;
  assign bus.rom_addr   = rom_addr;
  assign bus.color      = color;
  assign bus.fine_out   = fine_out;
  assign bus.tile_valid = (state == EMIT);
  assign bus.overrun    = overrun;

endmodule

// File: tb/tb_k052109_tile_fetch.sv
// Bench for k052109_tile_fetch: VRAM responder plus an arithmetic tile model, checked every cycle.
module tb_k052109_tile_fetch;

  localparam int CODE_A = 'h0000;
  localparam int ATTR_A = 'h0800;
  localparam int ATTR_W = 'h1F00;

  logic clk;
  logic rst;

  k052109_tile_fetch_if ifa ();
  k052109_tile_fetch_if ifw ();

  k052109_tile_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  k052109_tile_fetch #(
    .CODE_BASE (13'h0000),
    .ATTR_BASE (13'h1F00),
    .FLIPY_EN  (1'b1)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (ifw)
  );

  assign ifw.start     = ifa.start;
  assign ifw.map       = ifa.map;
  assign ifw.row_s     = ifa.row_s;
  assign ifw.fine      = ifa.fine;
  assign ifw.bank_we   = ifa.bank_we;
  assign ifw.bank_sel  = ifa.bank_sel;
  assign ifw.bank_data = ifa.bank_data;
  assign ifw.vram_wait = ifa.vram_wait;
  assign ifw.vd_in     = ifa.vd_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  vram [8192];
  logic [3:0]  bank_m [4];
  bit          ov;
  logic [15:0] hold_rom;
  logic [3:0]  hold_col;
  logic [2:0]  hold_fine;
  logic [12:0] last_wrap;
  int          npass = 0;
  int          ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [12:0] vaddr(input int base, input logic [10:0] m);
    return 13'((base + int'(m)) % 8192);
  endfunction

  function automatic logic [15:0] ref_rom(input logic [10:0] m, input logic [2:0] r);
    int code, attr, tile, row;
    code = int'(vram[vaddr(CODE_A, m)]);
    attr = int'(vram[vaddr(ATTR_A, m)]);
    tile = int'(bank_m[2'((attr / 4) % 4)]) * 512 + (attr % 2) * 256 + code;
    row  = ((attr / 2) % 2 == 1) ? 7 - int'(r) : int'(r);
    return 16'(tile * 8 + row);
  endfunction

  // One clock: latch the request seen this cycle, answer it in the next cycle.
  task automatic tick();
    logic        acc;
    logic [12:0] a;
    acc = ifa.vram_rd && !ifa.vram_wait;
    a   = ifa.vram_addr;
    @(negedge clk);
    ifa.vd_in   = acc ? vram[a] : 8'($urandom);
    ifa.bank_we = 1'b0;
  endtask

  task automatic scramble();
    ifa.start = 1'b0;
    ifa.map   = 11'($urandom);
    ifa.row_s = 3'($urandom);
    ifa.fine  = 3'($urandom);
  endtask

  task automatic set_bank(input logic [1:0] idx, input logic [3:0] val);
    ifa.bank_we   = 1'b1;
    ifa.bank_sel  = idx;
    ifa.bank_data = val;
    bank_m[idx]   = val;
    tick();
  endtask

  task automatic idle(input int n, input bit wr);
    logic [1:0] idx;
    for (int i = 0; i < n; i++) begin
      ifa.vram_wait = 1'($urandom);
      chk("idle_tile_valid", 32'(ifa.tile_valid), 32'(0));
      chk("idle_vram_rd", 32'(ifa.vram_rd), 32'(0));
      chk("hold_rom_addr", 32'(ifa.rom_addr), 32'(hold_rom));
      chk("hold_color", 32'(ifa.color), 32'(hold_col));
      chk("hold_fine_out", 32'(ifa.fine_out), 32'(hold_fine));
      chk("idle_overrun", 32'(ifa.overrun), 32'(ov));
      if (wr) begin
        idx           = 2'($urandom);
        ifa.bank_we   = 1'b1;
        ifa.bank_sel  = idx;
        ifa.bank_data = 4'($urandom);
        bank_m[idx]   = ifa.bank_data;
      end
      tick();
    end
  endtask

  // Returns at the negedge of the TILE_VALID cycle without advancing past it.
  task automatic fetch(input logic [10:0] m, input logic [2:0] r, input logic [2:0] f,
                       input int sc, input int sa, input int abort_at, input bit emit_wr);
    int          cyc, t, ab;
    logic [10:0] cm;
    logic [2:0]  cr, cf;
    logic [7:0]  attr;
    logic [1:0]  idx;
    cm = m; cr = r; cf = f; ab = abort_at;
    ifa.start = 1'b1; ifa.map = cm; ifa.row_s = cr; ifa.fine = cf; ifa.vram_wait = 1'b0;
    tick();
    scramble();
    t = sc + sa + 4;
    cyc = 1;
    while (cyc <= t) begin
      ifa.vram_wait = (cyc <= sc) || (cyc >= sc + 2 && cyc <= sc + sa + 1);
      if (cyc <= sc + 1) begin
        chk("code_vram_rd", 32'(ifa.vram_rd), 32'(1));
        chk("code_addr", 32'(ifa.vram_addr), 32'(vaddr(CODE_A, cm)));
      end else if (cyc <= sc + sa + 2) begin
        chk("attr_vram_rd", 32'(ifa.vram_rd), 32'(1));
        chk("attr_addr", 32'(ifa.vram_addr), 32'(vaddr(ATTR_A, cm)));
        chk("wrap_attr_addr", 32'(ifw.vram_addr), 32'(vaddr(ATTR_W, cm)));
        last_wrap = ifw.vram_addr;
      end else begin
        chk("vram_rd_off", 32'(ifa.vram_rd), 32'(0));
      end
      chk("tile_valid", 32'(ifa.tile_valid), 32'(cyc == t));
      if (cyc == ab) begin
        cm = 11'($urandom); cr = 3'($urandom); cf = 3'($urandom);
        ab = 0; sc = 0; sa = 0; t = 4; ov = 1'b1;
        ifa.start = 1'b1; ifa.map = cm; ifa.row_s = cr; ifa.fine = cf; ifa.vram_wait = 1'b0;
        tick();
        scramble();
        cyc = 1;
        continue;
      end
      if (cyc == t) begin
        hold_rom  = ref_rom(cm, cr);
        hold_col  = 4'(vram[vaddr(ATTR_A, cm)] / 16);
        hold_fine = cf;
        chk("rom_addr", 32'(ifa.rom_addr), 32'(hold_rom));
        chk("color", 32'(ifa.color), 32'(hold_col));
        chk("fine_out", 32'(ifa.fine_out), 32'(hold_fine));
        chk("overrun", 32'(ifa.overrun), 32'(ov));
        chk("wrap_tile_valid", 32'(ifw.tile_valid), 32'(1));
        chk("wrap_rom_addr", 32'(ifw.rom_addr), 32'(hold_rom));
        if (emit_wr) begin
          attr          = vram[vaddr(ATTR_A, cm)];
          idx           = 2'((int'(attr) / 4) % 4);
          ifa.bank_we   = 1'b1;
          ifa.bank_sel  = idx;
          ifa.bank_data = ~bank_m[idx];
          bank_m[idx]   = ~bank_m[idx];
        end
        cyc++;
      end else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vram_addr"}, 32'(ifa.vram_addr), 32'(0));
    chk({tag, "_vram_rd"}, 32'(ifa.vram_rd), 32'(0));
    chk({tag, "_rom_addr"}, 32'(ifa.rom_addr), 32'(0));
    chk({tag, "_color"}, 32'(ifa.color), 32'(0));
    chk({tag, "_fine_out"}, 32'(ifa.fine_out), 32'(0));
    chk({tag, "_tile_valid"}, 32'(ifa.tile_valid), 32'(0));
    chk({tag, "_overrun"}, 32'(ifa.overrun), 32'(0));
  endtask

  task automatic model_reset();
    foreach (bank_m[i]) bank_m[i] = '0;
    ov = 1'b0; hold_rom = '0; hold_col = '0; hold_fine = '0;
  endtask

  initial begin
    foreach (vram[i]) vram[i] = 8'($urandom);
    model_reset();
    last_wrap = '0;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.map = '0; ifa.row_s = '0; ifa.fine = '0;
    ifa.bank_we = 1'b0; ifa.bank_sel = '0; ifa.bank_data = '0;
    ifa.vram_wait = 1'b0; ifa.vd_in = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");
    idle(2, 1'b0);

    // Plain fetch
    vram[13'h0123] = 8'h4A; vram[13'h0923] = 8'h50;
    fetch(11'h123, 3'd5, 3'd2, 0, 0, 0, 1'b0);
    chk("plain_rom_const", 32'(ifa.rom_addr), 32'h0255);
    chk("plain_color_const", 32'(ifa.color), 32'h5);
    chk("plain_fine_const", 32'(ifa.fine_out), 32'h2);
    tick();
    idle(2, 1'b0);

    // Bank plus flip-Y
    set_bank(2'd2, 4'hB);
    vram[13'h0010] = 8'h01; vram[13'h0810] = 8'hFB;
    fetch(11'h010, 3'd3, 3'd6, 0, 0, 0, 1'b0);
    chk("flip_rom_const", 32'(ifa.rom_addr), 32'hB80C);
    chk("flip_color_const", 32'(ifa.color), 32'hF);
    tick();
    idle(1, 1'b0);

    // Stalls in code read, then in attribute read
    fetch(11'($urandom), 3'($urandom), 3'($urandom), 3, 0, 0, 1'b0);
    tick();
    idle(1, 1'b0);
    fetch(11'($urandom), 3'($urandom), 3'($urandom), 0, 2, 0, 1'b0);
    tick();
    idle(1, 1'b0);

    // Attribute address wrap on the second instance
    fetch(11'h180, 3'($urandom), 3'($urandom), 0, 0, 0, 1'b0);
    chk("wrap_const", 32'(last_wrap), 32'h0080);
    tick();
    idle(1, 1'b0);

    // EMIT-cycle bank write is unseen; START in EMIT begins a new fetch
    fetch(11'($urandom), 3'($urandom), 3'($urandom), 0, 0, 0, 1'b1);
    fetch(11'($urandom), 3'($urandom), 3'($urandom), 1, 1, 0, 1'b0);
    tick();
    idle(2, 1'b1);

    for (int k = 0; k < 14; k++) begin
      fetch(11'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        idle(int'($urandom_range(0, 2)), 1'b1);
      end
    end
    tick();
    idle(1, 1'b0);

    // Overrun: second START in RD_ATTR
    fetch(11'($urandom), 3'($urandom), 3'($urandom), 0, 0, 2, 1'b0);
    tick();
    idle(3, 1'b1);
    fetch(11'($urandom), 3'($urandom), 3'($urandom), 1, 0, 0, 1'b0);
    tick();
    idle(1, 1'b0);

    // Reset during RD_ATTR
    set_bank(2'd0, 4'h3); set_bank(2'd1, 4'h5); set_bank(2'd2, 4'h9); set_bank(2'd3, 4'hE);
    ifa.start = 1'b1; ifa.map = 11'($urandom); ifa.vram_wait = 1'b0;
    tick();
    scramble();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_zero("midreset");
    idle(3, 1'b0);
    vram[13'h0A55] = 8'h3E;
    fetch(11'h255, 3'($urandom), 3'($urandom), 0, 0, 0, 1'b0);
    tick();
    idle(1, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
